// File: rtl/cache_pkg.sv
// Shared types for the cache CPU-port initiator: FSM state encoding,
// default-width command/response bundles and the strobe-width helper.
package cache_pkg;

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    localparam int CACHE_ADDR_WIDTH = 32;
    localparam int CACHE_DATA_WIDTH = 32;
    localparam int STRB_WIDTH       = strb_width(CACHE_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef struct packed {
        logic                        we;
        logic [CACHE_ADDR_WIDTH-1:0] addr;
        logic [CACHE_DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0]       wstrb;
    } cmd_t;

    typedef struct packed {
        logic                        we;
        logic [CACHE_DATA_WIDTH-1:0] rdata;
        logic                        err;
    } rsp_t;

endpackage

// File: rtl/cache_cmd_fifo.sv
// Synchronous command FIFO. Ports: push/wdata in, pop/rdata (head) out,
// full/empty flags. Pointers carry one extra MSB to tell full from empty.
module cache_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cache_cpu_master.sv
// CPU-side initiator for the cache: buffers cmd_* commands, issues them one
// at a time on cpu_*, returns one rsp_* per command in order; rsp_err marks
// a REQ timeout. Define CACHE_CPU_MASTER_STATS_EN for stat_* counter ports.
module cache_cpu_master
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_we,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      cpu_req,
    output logic                      cpu_we,
    output logic [ADDR_WIDTH-1:0]     cpu_addr,
    output logic [DATA_WIDTH-1:0]     cpu_wdata,
    output logic [DATA_WIDTH/8-1:0]   cpu_wstrb,
    input  logic                      cpu_ready,
    input  logic [DATA_WIDTH-1:0]     cpu_rdata
`ifdef CACHE_CPU_MASTER_STATS_EN
    ,
    output logic [31:0]               stat_reads,
    output logic [31:0]               stat_writes,
    output logic [15:0]               stat_timeouts,
    output logic [31:0]               stat_busy_cycles
`endif
);

    localparam int SW = strb_width(DATA_WIDTH);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         wstrb;
    } cmd_bus_t;

    cmd_bus_t      push_cmd;
    cmd_bus_t      head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          done;
    logic          abort;
    logic          timeout_hit;
    logic [CW-1:0] cnt;
    state_t        state;
    state_t        state_n;

    assign cmd_ready   = !full;
    assign push_cmd    = '{cmd_we, cmd_addr, cmd_wdata, cmd_wstrb};
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == LIMIT);

    cache_cmd_fifo #(
        .WIDTH($bits(cmd_bus_t)),
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (cmd_valid && !full),
        .wdata(push_cmd),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // cpu_ready has priority over a coinciding timeout expiry.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (cpu_ready) begin
                    done    = 1'b1;
                    state_n = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = REQ;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_req   <= 1'b0;
            cpu_we    <= 1'b0;
            cpu_addr  <= '0;
            cpu_wdata <= '0;
            cpu_wstrb <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            if (pop) begin
                cpu_req   <= 1'b1;
                cpu_we    <= head.we;
                cpu_addr  <= head.addr;
                cpu_wdata <= head.wdata;
                cpu_wstrb <= head.wstrb;
                cnt       <= '0;
            end else begin
                if (done || abort) cpu_req <= 1'b0;
                if (state == REQ && cnt != '1) cnt <= cnt + 1'b1;
            end
            if (done) begin
                rsp_valid <= 1'b1;
                rsp_we    <= cpu_we;
                rsp_rdata <= cpu_we ? '0 : cpu_rdata;
                rsp_err   <= 1'b0;
            end else if (abort) begin
                rsp_valid <= 1'b1;
                rsp_we    <= cpu_we;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef CACHE_CPU_MASTER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads       <= '0;
            stat_writes      <= '0;
            stat_timeouts    <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (done && !cpu_we && stat_reads != '1)
                stat_reads <= stat_reads + 1'b1;
            if (done && cpu_we && stat_writes != '1)
                stat_writes <= stat_writes + 1'b1;
            if (abort && stat_timeouts != '1)
                stat_timeouts <= stat_timeouts + 1'b1;
            if (state == REQ && stat_busy_cycles != '1)
                stat_busy_cycles <= stat_busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_cpu_master.sv
// Directed self-checking bench for cache_cpu_master (TIMEOUT_CYCLES=16).
// Bench drives the cache side by hand; expected values are hand-computed.
module tb_cache_cpu_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;

    int total = 0;
    int bad   = 0;

    cache_cpu_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .CMD_DEPTH     (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_we   (rsp_we),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_we    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic serve(input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic [31:0] rd);
        chk("srv_req", cpu_req, 1);
        chk("srv_addr", cpu_addr, a);
        chk("srv_we", cpu_we, w);
        chk("srv_wdata", cpu_wdata, d);
        chk("srv_wstrb", cpu_wstrb, s);
        cpu_ready = 1'b1;
        cpu_rdata = rd;
        tick();
        cpu_ready = 1'b0;
        chk("srv_rsp_valid", rsp_valid, 1);
        chk("srv_rsp_we", rsp_we, w);
        chk("srv_rsp_rdata", rsp_rdata, w ? 32'h0 : rd);
        chk("srv_rsp_err", rsp_err, 0);
        chk("srv_req_drop", cpu_req, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("srv_rsp_clr", rsp_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        #3;
        chk("rst_cpu_req", cpu_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_err", rsp_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single read, 5-cycle cache latency
        push(0, 32'h0000_0040, 32'h0, 4'h0);
        chk("lat_1cyc", cpu_req, 0);
        tick();
        chk("lat_2cyc", cpu_req, 1);
        chk("rd_addr", cpu_addr, 32'h40);
        chk("rd_we", cpu_we, 0);
        repeat (4) tick();
        chk("rd_hold", cpu_req, 1);
        cpu_ready = 1'b1;
        cpu_rdata = 32'hDEAD_BEEF;
        tick();
        cpu_ready = 1'b0;
        cpu_rdata = 32'h0BAD_0BAD;
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_we", rsp_we, 0);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);

        // backpressure: 10 cycles with a queued command
        push(1, 32'h200, 32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 9; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("bp_no_issue", cpu_req, 0);
            tick();
        end
        chk("bp_last_req", cpu_req, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_rsp_clr", rsp_valid, 0);
        chk("bp_resume", cpu_req, 1);
        serve(32'h200, 1, 32'hCAFE_F00D, 4'hF, 32'h1234_5678);
        chk("bp_idle", cpu_req, 0);

        // back-to-back four commands
        push(1, 32'h100, 32'h1122_3344, 4'hF);
        push(0, 32'h100, 32'h0, 4'h0);
        push(1, 32'h104, 32'h5566_7788, 4'h3);
        push(0, 32'h104, 32'h0, 4'h0);
        serve(32'h100, 1, 32'h1122_3344, 4'hF, 32'h0);
        serve(32'h100, 0, 32'h0, 4'h0, 32'h1122_3344);
        serve(32'h104, 1, 32'h5566_7788, 4'h3, 32'h0);
        serve(32'h104, 0, 32'h0, 4'h0, 32'h0000_7788);
        chk("b2b_idle", cpu_req, 0);

        // FIFO full with the cache stalled
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        for (int i = 0; i < 5; i++) begin
            cmd_addr = 32'h300 + 32'(4 * i);
            tick();
        end
        chk("full_ready", cmd_ready, 0);
        chk("full_head", cpu_addr, 32'h300);
        cmd_addr = 32'h314;
        tick();
        chk("full_stall1", cmd_ready, 0);
        tick();
        chk("full_stall2", cmd_ready, 0);
        cpu_ready = 1'b1;
        cpu_rdata = 32'hA0;
        tick();
        cpu_ready = 1'b0;
        chk("full_rsp", rsp_rdata, 32'hA0);
        chk("full_still", cmd_ready, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("full_free", cmd_ready, 1);
        chk("full_next", cpu_addr, 32'h304);
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i < 6; i++)
            serve(32'h300 + 32'(4 * i), 0, 32'h0, 4'h0, 32'hA0 + 32'(i));
        chk("full_idle", cpu_req, 0);
        chk("full_empty_rdy", cmd_ready, 1);

        // timeout with no cpu_ready
        cpu_rdata = 32'hFFFF_0000;
        push(0, 32'h500, 32'h0, 4'h0);
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_hold", cpu_req, 1);
        end
        tick();
        chk("to_req_drop", cpu_req, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // cpu_ready on the last allowed REQ cycle
        push(0, 32'h600, 32'h0, 4'h0);
        tick();
        repeat (15) tick();
        chk("edge_hold", cpu_req, 1);
        cpu_ready = 1'b1;
        cpu_rdata = 32'h600D_600D;
        tick();
        cpu_ready = 1'b0;
        chk("edge_valid", rsp_valid, 1);
        chk("edge_err", rsp_err, 0);
        chk("edge_rdata", rsp_rdata, 32'h600D_600D);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("edge_clr", rsp_valid, 0);

        // reset while in REQ with two queued commands
        push(0, 32'h700, 32'h0, 4'h0);
        push(0, 32'h704, 32'h0, 4'h0);
        push(0, 32'h708, 32'h0, 4'h0);
        chk("mid_req", cpu_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_req_async", cpu_req, 0);
        chk("mid_cmd_ready", cmd_ready, 1);
        chk("mid_rsp_valid", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_no_issue", cpu_req, 0);
            chk("post_rsp_valid", rsp_valid, 0);
        end
        push(1, 32'h800, 32'hA5A5_5A5A, 4'h5);
        tick();
        serve(32'h800, 1, 32'hA5A5_5A5A, 4'h5, 32'h0);
        chk("post_idle", cpu_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_cpu_master.md
Name: cache_cpu_master

Overview:
- CPU-side initiator for the cache CPU port (cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_wstrb -> cpu_ready/cpu_rdata).
- Accepts read/write commands on a valid/ready stream and buffers them in a command FIFO.
- Issues commands to the cache one at a time and returns one response per command on a valid/ready stream.
- Drives the cache in SoC integration and in self-checking benches.

Parameters:
ADDR_WIDTH, 32, cache address width
DATA_WIDTH, 32, data width; multiple of 8
CMD_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 1024, maximum cycles in REQ before abort; 0 disables the timeout

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command FIFO not full
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  byte enables
rsp_valid  out  1  response held
rsp_ready  in  1  response consumer ready
rsp_we  out  1  echo of command type
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  timeout abort
cpu_req  out  1  to cache
cpu_we  out  1  to cache
cpu_addr  out  ADDR_WIDTH  to cache
cpu_wdata  out  DATA_WIDTH  to cache
cpu_wstrb  out  DATA_WIDTH/8  to cache
cpu_ready  in  1  from cache; transfer completes on the cycle it is high while cpu_req=1
cpu_rdata  in  DATA_WIDTH  from cache; valid with cpu_ready on reads

Behaviour:
- Reset:
  - Asynchronous; all outputs go to 0 immediately, except cmd_ready=1 after reset.
  - FIFO is emptied, FSM returns to IDLE, and the timeout counter is cleared.
- Command push:
  - Occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full and is independent of cmd_valid.
  - No pass-through on full, even when a pop happens in the same cycle.
- FSM states IDLE, REQ, RESP:
  - IDLE -> REQ when the FIFO is non-empty.
    - Pops the head and registers it into cpu_* outputs.
    - cpu_req=1 from the next cycle.
    - Minimum latency from command push to cpu_req=1 is 2 cycles.
  - REQ:
    - cpu_req and all cpu_* outputs are held stable.
    - When cpu_ready=1: capture cpu_rdata (reads) or 0 (writes), set rsp_valid=1, rsp_err=0, drop cpu_req on the next cycle, go to RESP.
  - REQ timeout:
    - Applies when TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 without cpu_ready.
    - Drops cpu_req, sets rsp_valid=1, rsp_err=1, rsp_rdata=0, goes to RESP.
    - If cpu_ready and expiry coincide, cpu_ready wins (normal completion).
  - RESP:
    - rsp_* are held stable until rsp_ready=1.
    - Then rsp_valid=0 and the state becomes IDLE, or REQ directly with the next head when the FIFO is non-empty (back-to-back, no idle bubble).
- Exactly one outstanding cache transaction at any time.
- Responses are returned in command order.
- rsp_valid never drops without rsp_ready.
- The timeout counter resets on entry to REQ. It saturates and does not wrap.
- After any rsp_err the cache state is undefined; the system must reset both blocks.
- FIFO pointers are log2(CMD_DEPTH)+1 bits, so full and empty are distinguished by the MSB. Pointers wrap modulo 2*CMD_DEPTH.

Optional Feature:
- Macro: CACHE_CPU_MASTER_STATS_EN.
- When defined, adds these outputs, cleared on reset and saturating at all-ones:
  - stat_reads: 32 bits, completed reads.
  - stat_writes: 32 bits, completed writes.
  - stat_timeouts: 16 bits, timeout aborts.
  - stat_busy_cycles: 32 bits, cycles spent in REQ.
- When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg holds:
  - FSM state enum (IDLE/REQ/RESP);
  - command struct {we, addr, wdata, wstrb};
  - response struct {we, rdata, err};
  - helper constant STRB_WIDTH = DATA_WIDTH/8.
- One sub-module, cache_cmd_fifo: a synchronous FIFO parameterised by width and depth, with push/pop/full/empty.

Test Plan:
- Single read: push read at 0x0000_0040; cache returns cpu_ready with cpu_rdata=0xDEADBEEF after 5 cycles -> one response rsp_valid=1, rsp_we=0, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Back-to-back: push 4 commands (W 0x100=0x11223344 strb 0xF, R 0x100, W 0x104 strb 0x3, R 0x104) with rsp_ready=1 -> four responses in order; cpu_req re-asserts the cycle after each rsp handshake.
- FIFO full: CMD_DEPTH=4, cpu_ready held low, push 6 commands -> cmd_ready=0 after the FIFO holds 4 entries while the 5th is in REQ; the 6th is stalled and not lost.
- Response backpressure: rsp_ready=0 for 10 cycles after completion -> rsp_* stable, cpu_req stays 0, no new issue; issue resumes the cycle after rsp_ready=1.
- Timeout: TIMEOUT_CYCLES=16, cpu_ready never asserted -> cpu_req drops after 16 REQ cycles, rsp_err=1, rsp_rdata=0. A separate case with cpu_ready on cycle 16 -> rsp_err=0.
- Reset mid-transaction: rst_n low while in REQ with 2 queued commands -> cpu_req=0 immediately; after release cmd_ready=1, rsp_valid=0, and no stale command is issued.
